// File: rtl/pipe_mult_hs.sv
// Pipelined WIDTH x WIDTH multiplier with valid/ready on both sides.
// The product is formed on entry and then carried with its tag through STAGES registers.
module pipe_mult_hs #(
  parameter  int WIDTH  = 8,
  parameter  int STAGES = 3,
  parameter  int TAG_W  = 4,
  localparam int PW     = 2 * WIDTH,
  localparam int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    result,
  output logic [TAG_W-1:0] tag_out,
  output logic [OCC_W-1:0] occupancy
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high. The pipe freezes as a whole only while the output holds an
  // unaccepted result, so in_ready is simply the inverse of that stall.
  logic             w_stall;
  logic             w_accept;
  logic             w_out_hs;
  logic [PW-1:0]    w_a_ext;
  logic [PW-1:0]    w_b_ext;
  logic [PW-1:0]    w_prod;

  logic             r_vld  [STAGES];
  logic [PW-1:0]    r_prod [STAGES];
  logic [TAG_W-1:0] r_tag  [STAGES];
  logic [OCC_W-1:0] r_occ;

  assign w_stall  = r_vld[STAGES-1] & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_accept = in_valid & in_ready;
  assign w_out_hs = r_vld[STAGES-1] & out_ready;

  // Sign-extending to 2*WIDTH makes one unsigned multiply serve both modes,
  // because the low 2*WIDTH bits of the product are identical either way.
  assign w_a_ext = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
  assign w_b_ext = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_vld[i]  <= 1'b0;
        r_prod[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else if (!w_stall) begin
      r_vld[0] <= w_accept;
      if (w_accept) begin
        r_prod[0] <= w_prod;
        r_tag[0]  <= tag_in;
      end
      // Bubbles advance too, but leave the data behind them untouched so the
      // output keeps showing the last real result.
      for (int i = 1; i < STAGES; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_prod[i] <= r_prod[i-1];
          r_tag[i]  <= r_tag[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_occ <= '0;
    end else begin
      case ({w_accept, w_out_hs})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign result    = r_prod[STAGES-1];
  assign tag_out   = r_tag[STAGES-1];
  assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_mult_hs.sv
// Bench for pipe_mult_hs: three configurations (8/3, 16/1, 16/5) each checked every cycle
// against an accept-order queue model, plus directed literal checks on the 8/3 instance.
module tb_pipe_mult_hs;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        drv_valid  [3];
  logic [15:0] drv_a      [3];
  logic [15:0] drv_b      [3];
  logic        drv_signed [3];
  logic [3:0]  drv_tag    [3];
  logic        drv_ready  [3];

  logic        p0_valid;
  logic        p0_in_ready;
  logic [15:0] p0_result;
  logic [3:0]  p0_tag;
  logic [1:0]  p0_occ;

  task automatic chk(input int cfg, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL cfg%0d %s got=%0h expected=%0h", cfg, nm, act, exp);
    end
  endtask

  // Signed/unsigned product of w-bit operands, reduced mod 2^(2w).
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic s);
    longint xv, yv, p;
    xv = longint'(x) & ((longint'(1) << w) - 1);
    yv = longint'(y) & ((longint'(1) << w) - 1);
    if (s && x[w-1]) xv = xv - (longint'(1) << w);
    if (s && y[w-1]) yv = yv - (longint'(1) << w);
    p = xv * yv;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int W  = (g == 0) ? 8 : 16;
    localparam int S  = (g == 0) ? 3 : ((g == 1) ? 1 : 5);
    localparam int OW = $clog2(S + 1);

    logic           in_ready;
    logic           out_valid;
    logic [2*W-1:0] result;
    logic [3:0]     tag_out;
    logic [OW-1:0]  occ;

    pipe_mult_hs #(.WIDTH(W), .STAGES(S), .TAG_W(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (drv_valid[g]),
      .in_ready  (in_ready),
      .a         (drv_a[g][W-1:0]),
      .b         (drv_b[g][W-1:0]),
      .is_signed (drv_signed[g]),
      .tag_in    (drv_tag[g]),
      .out_valid (out_valid),
      .out_ready (drv_ready[g]),
      .result    (result),
      .tag_out   (tag_out),
      .occupancy (occ)
    );

    if (g == 0) begin : g_p0
      assign p0_valid    = out_valid;
      assign p0_in_ready = in_ready;
      assign p0_result   = result;
      assign p0_tag      = tag_out;
      assign p0_occ      = occ;
    end

    // Model: ops accepted but not yet handed off, in accept order, with the
    // cycle they entered and the stall count at that time.
    logic [31:0] exp_q[$];
    logic [3:0]  exp_tag_q[$];
    int          acc_cyc_q[$];
    int          acc_stall_q[$];
    int          cyc = 0;
    int          stall_tot = 0;
    logic        prev_stall = 1'b0;
    logic        armed = 1'b0;
    logic        after_rst = 1'b0;

    always @(negedge clk) begin
      logic stall;
      cyc++;
      if (!reset_n) begin
        exp_q.delete(); exp_tag_q.delete(); acc_cyc_q.delete(); acc_stall_q.delete();
        armed = 1'b1; after_rst = 1'b1; prev_stall = 1'b0;
      end else if (armed) begin
        if (after_rst) begin
          chk(g, "rst_result", 32'(result), 32'd0);
          chk(g, "rst_tag", 32'(tag_out), 32'd0);
          after_rst = 1'b0;
        end
        stall = out_valid && !drv_ready[g];
        chk(g, "in_ready", 32'(in_ready), 32'(!stall));
        chk(g, "occupancy", 32'(occ), 32'(exp_q.size()));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk(g, "out_valid_extra", 32'(out_valid), 32'd0);
          end else begin
            chk(g, "result", 32'(result), exp_q[0]);
            chk(g, "tag_out", 32'(tag_out), 32'(exp_tag_q[0]));
            if (!prev_stall)
              chk(g, "latency", 32'(cyc - acc_cyc_q[0]), 32'(S + stall_tot - acc_stall_q[0]));
          end
        end else if (exp_q.size() > 0 && (cyc - acc_cyc_q[0]) >= S + stall_tot - acc_stall_q[0]) begin
          chk(g, "out_valid_late", 32'(out_valid), 32'd1);
        end
        if (out_valid && drv_ready[g] && exp_q.size() > 0) begin
          void'(exp_q.pop_front()); void'(exp_tag_q.pop_front());
          void'(acc_cyc_q.pop_front()); void'(acc_stall_q.pop_front());
        end
        if (drv_valid[g] && in_ready) begin
          exp_q.push_back(ref_mul(W, drv_a[g], drv_b[g], drv_signed[g]));
          exp_tag_q.push_back(drv_tag[g]);
          acc_cyc_q.push_back(cyc);
          acc_stall_q.push_back(stall_tot);
        end
        if (stall) stall_tot++;
        prev_stall = stall;
      end
    end
  end

  logic [15:0] op_a[16];
  logic [15:0] op_b[16];
  logic        op_s[16];
  logic [3:0]  op_t[16];
  logic [15:0] got_res[$];
  logic [3:0]  got_tag[$];
  int first_c, max_occ, stall_c, occ_at5;

  task automatic set_op(input int i, input logic [15:0] x, input logic [15:0] y,
                        input logic s, input logic [3:0] t);
    op_a[i] = x; op_b[i] = y; op_s[i] = s; op_t[i] = t;
  endtask

  // Streams n ops into the 8/3 instance, holding out_ready low for stream
  // cycles lo_from..lo_to, and records outputs in handoff order.
  task automatic stream0(input int n, input int lo_from, input int lo_to);
    int i, c;
    i = 0; c = 0;
    got_res.delete(); got_tag.delete();
    first_c = -1; max_occ = 0; stall_c = 0; occ_at5 = -1;
    while ((i < n || got_res.size() < n) && c < 200) begin
      @(posedge clk); #1;
      drv_valid[0] = (i < n);
      if (i < n) begin
        drv_a[0] = op_a[i]; drv_b[0] = op_b[i];
        drv_signed[0] = op_s[i]; drv_tag[0] = op_t[i];
      end
      drv_ready[0] = !(c >= lo_from && c <= lo_to);
      @(negedge clk);
      if (c == 5) occ_at5 = int'(p0_occ);
      if (int'(p0_occ) > max_occ) max_occ = int'(p0_occ);
      if (!p0_in_ready) stall_c++;
      if (p0_valid && drv_ready[0]) begin
        if (first_c < 0) first_c = c;
        got_res.push_back(p0_result);
        got_tag.push_back(p0_tag);
      end
      if (drv_valid[0] && p0_in_ready) i++;
      c++;
    end
    @(posedge clk); #1;
    drv_valid[0] = 1'b0; drv_ready[0] = 1'b1;
    chk(0, "stream_count", 32'(got_res.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      drv_valid[k] = 1'b0; drv_a[k] = '0; drv_b[k] = '0;
      drv_signed[k] = 1'b0; drv_tag[k] = '0; drv_ready[k] = 1'b1;
    end
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk(0, "reset_out_valid", 32'(p0_valid), 32'd0);
    chk(0, "reset_occ", 32'(p0_occ), 32'd0);
    chk(0, "reset_in_ready", 32'(p0_in_ready), 32'd1);

    // Single unsigned op.
    set_op(0, 16'd255, 16'd255, 1'b0, 4'd5);
    stream0(1, -1, -1);
    chk(0, "t1_latency", 32'(first_c), 32'd3);
    if (got_res.size() == 1) begin
      chk(0, "t1_result", 32'(got_res[0]), 32'h0000_FE01);
      chk(0, "t1_tag", 32'(got_tag[0]), 32'd5);
    end

    // Signed corner products, then the same bits unsigned.
    set_op(0, 16'h80, 16'h80, 1'b1, 4'd1);
    set_op(1, 16'hFF, 16'hFF, 1'b1, 4'd2);
    set_op(2, 16'h80, 16'h7F, 1'b1, 4'd3);
    set_op(3, 16'hFF, 16'hFF, 1'b0, 4'd4);
    stream0(4, -1, -1);
    if (got_res.size() == 4) begin
      chk(0, "t2_m128_m128", 32'(got_res[0]), 32'h0000_4000);
      chk(0, "t2_m1_m1", 32'(got_res[1]), 32'h0000_0001);
      chk(0, "t2_m128_127", 32'(got_res[2]), 32'h0000_C080);
      chk(0, "t2_ff_ff_uns", 32'(got_res[3]), 32'h0000_FE01);
    end

    // Back-pressure during a 10-op stream.
    for (int k = 0; k < 10; k++)
      set_op(k, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 4'(k));
    stream0(10, 4, 7);
    chk(0, "t3_stall_cycles", 32'(stall_c), 32'd4);
    chk(0, "t3_max_occ_over", 32'(max_occ > 3), 32'd0);
    for (int k = 0; k < got_tag.size(); k++)
      chk(0, "t3_tag_order", 32'(got_tag[k]), 32'(k));

    // Full pipe with continuous accept and drain.
    for (int k = 0; k < 8; k++)
      set_op(k, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 4'(k));
    stream0(8, -1, -1);
    chk(0, "t5_occ_full", 32'(occ_at5), 32'd3);
    chk(0, "t5_no_stall", 32'(stall_c), 32'd0);

    // Reset with three ops in flight.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      drv_valid[0] = 1'b1; drv_a[0] = 16'(k + 3); drv_b[0] = 16'd7;
      drv_signed[0] = 1'b0; drv_tag[0] = 4'(k + 8); drv_ready[0] = 1'b1;
    end
    @(posedge clk); #1;
    drv_valid[0] = 1'b0; reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk(0, "t4_out_valid", 32'(p0_valid), 32'd0);
      chk(0, "t4_occ", 32'(p0_occ), 32'd0);
    end
    set_op(0, 16'd12, 16'd10, 1'b0, 4'd9);
    stream0(1, -1, -1);
    chk(0, "t4_latency", 32'(first_c), 32'd3);
    if (got_res.size() == 1) chk(0, "t4_result", 32'(got_res[0]), 32'd120);

    // Random traffic on all three configurations at once.
    repeat (600) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        drv_valid[k]  = ($urandom_range(0, 9) < 7);
        drv_a[k]      = 16'($urandom);
        drv_b[k]      = 16'($urandom);
        drv_signed[k] = 1'($urandom_range(0, 1));
        drv_tag[k]    = 4'($urandom_range(0, 15));
        drv_ready[k]  = ($urandom_range(0, 3) != 0);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      drv_valid[k] = 1'b0; drv_ready[k] = 1'b1;
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk(0, "drain_occ", 32'(p0_occ), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
